// File: rtl/ycell_cfg_loader_if.sv
// Host-side word bus of the yellow-cell config loader: write channel (valid/ready)
// and the readback channel, which the loader drives only when readback is built in.
interface ycell_cfg_loader_if #(
  parameter int COLS  = 4,
  parameter int CBITS = 3
);
  logic [COLS*CBITS-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic [COLS*CBITS-1:0] rdata;
  logic                  rvalid;

  modport master (output wdata, wvalid, input wready, rdata, rvalid);
  modport slave  (input wdata, wvalid, output wready, rdata, rvalid);
endinterface

// File: rtl/ycell_cfg_loader.sv
// Row-parallel to column-serial configuration loader for a Morphle yellow-cell array.
// Define CFG_READBACK_EN to return the displaced chain contents as readback words.
module ycell_cfg_loader #(
  parameter int COLS  = 4,
  parameter int ROWS  = 8,
  parameter int CBITS = 3
) (
  input  logic              confclk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [COLS-1:0]   cbit,
  output logic              shift_en,
  output logic              arr_reset,
  input  logic [COLS-1:0]   cbitret,
  ycell_cfg_loader_if.slave bus
);
  localparam int W  = COLS * CBITS;
  localparam int BW = (CBITS > 1) ? $clog2(CBITS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(CBITS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;

  state_t          r_state;
  logic            r_busy;
  logic            r_done;
  logic            r_wready;
  logic            r_shift_en;
  logic            r_arr_reset;
  logic [BW-1:0]   r_bitcnt;
  logic [RW-1:0]   r_rowcnt;
  logic [W-1:0]    r_sreg;
  logic [W-1:0]    w_sreg_shift;
  logic [COLS-1:0] w_msb;

  // Each column field shifts left on its own, so its MSB is always the next bit out.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    assign w_msb[gi] = r_sreg[gi*CBITS + CBITS - 1];
    if (CBITS > 1) begin : g_shift
      assign w_sreg_shift[gi*CBITS +: CBITS] = {r_sreg[gi*CBITS +: CBITS-1], 1'b0};
    end else begin : g_noshift
      assign w_sreg_shift[gi*CBITS] = 1'b0;
    end
  end

  always_ff @(posedge confclk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wready    <= 1'b0;
      r_shift_en  <= 1'b0;
      r_arr_reset <= 1'b1;
      r_bitcnt    <= '0;
      r_rowcnt    <= '0;
      r_sreg      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_FETCH;
            r_busy      <= 1'b1;
            r_arr_reset <= 1'b1;
            r_wready    <= 1'b1;
            r_rowcnt    <= '0;
          end
        end
        S_FETCH: begin
          if (bus.wvalid && r_wready) begin
            r_sreg     <= bus.wdata;
            r_bitcnt   <= '0;
            r_wready   <= 1'b0;
            r_shift_en <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_sreg <= w_sreg_shift;
          if (r_bitcnt == LAST_BIT) begin
            r_shift_en <= 1'b0;
            if (r_rowcnt == LAST_ROW) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_rowcnt <= r_rowcnt + RW'(1);
              r_wready <= 1'b1;
              r_state  <= S_FETCH;
            end
          end else begin
            r_bitcnt <= r_bitcnt + BW'(1);
          end
        end
        S_DONE: begin
          r_arr_reset <= 1'b0;
          r_rowcnt    <= '0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign shift_en  = r_shift_en;
  assign arr_reset = r_arr_reset;
  assign bus.wready = r_wready;
  // Keep the chain input quiet whenever the cells are not shifting.
  assign cbit = w_msb & {COLS{r_shift_en}};

`ifdef CFG_READBACK_EN
  logic [W-1:0] r_rdata;
  logic [W-1:0] w_rdata_shift;
  logic         r_rvalid;

  for (genvar gi = 0; gi < COLS; gi++) begin : g_rb
    if (CBITS > 1) begin : g_shift
      assign w_rdata_shift[gi*CBITS +: CBITS] = {r_rdata[gi*CBITS +: CBITS-1], cbitret[gi]};
    end else begin : g_noshift
      assign w_rdata_shift[gi*CBITS] = cbitret[gi];
    end
  end

  // rdata doubles as the accumulator; it is only meaningful while rvalid is high.
  always_ff @(posedge confclk) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= r_shift_en && (r_bitcnt == LAST_BIT);
      if (r_shift_en) begin
        r_rdata <= w_rdata_shift;
      end
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
`else
  logic w_unused_cbitret;
  assign w_unused_cbitret = ^cbitret;
  assign bus.rdata  = '0;
  assign bus.rvalid = 1'b0;
`endif
endmodule

// File: doc/ycell_cfg_loader.md
Name: ycell_cfg_loader

Overview:
- Synchronous configuration loader for a Morphle Logic array of yellow cells, COLS columns by ROWS rows.
- Accepts one row of cell configurations per parallel word over a valid/ready handshake.
- Serialises each word into COLS independent column shift chains (CBITS bits per cell) and holds the array in reset until the full array is loaded.
- Sits between the host/bus interface and the cell array; the array's config chain is clocked by confclk with shift_en as enable.

Parameters:
- COLS, 4, number of cell columns, one serial config chain each.
- ROWS, 8, cells per column chain.
- CBITS, 3, configuration bits per cell.

Ports:
- confclk  in  1  single clock; loader and cell config registers
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle request to begin a full-array load
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the last bit of the last row has shifted
- wdata  in  COLS*CBITS  one row of config; field c = wdata[c*CBITS +: CBITS] is for column c
- wvalid  in  1  wdata valid
- wready  out  1  loader can accept wdata
- cbit  out  COLS  serial config bit to top cell of each column (its cbitin)
- shift_en  out  1  cells shift their config on this confclk edge
- arr_reset  out  1  reset to the whole cell array
- cbitret  in  COLS  cbitout of the bottom cell of each column
- rdata  out  COLS*CBITS  readback row (feature only)
- rvalid  out  1  readback row valid (feature only)

Behaviour:
- Reset values: busy=0, done=0, wready=0, shift_en=0, cbit=0, arr_reset=1, rvalid=0, rdata=0. All counters clear. The state machine returns to IDLE.
- IDLE: wready=0. arr_reset=1 until the first completed load, then 0. start moves to FETCH, sets busy=1 and arr_reset=1. start is ignored in every other state.
- FETCH: wready=1 and shift_en=0. On wvalid&wready, capture wdata into a shift register, clear bitcnt, go to SHIFT. wvalid while wready=0 is ignored; wdata is not sampled.
- SHIFT: wready=0 and shift_en=1 for exactly CBITS consecutive cycles.
  - cbit[c] is the MSB of field c; each cycle every field shifts left by one, so the field MSB is sent first.
  - After the CBITS-th cycle: if rowcnt==ROWS-1, go to DONE; otherwise increment rowcnt and go to FETCH.
- DONE: for one cycle, done=1, busy=0, shift_en=0, then arr_reset=0 and return to IDLE.
- Ordering: the first word accepted ends in the bottom row (ROWS-1); the last word ends in the top row (0). Within a cell, the first bit sent ends in the cell's config MSB.
- Latency: minimum CBITS+1 cycles per row; a full load takes ROWS*(CBITS+1)+1 cycles from start with wvalid held high.
- Counter widths: bitcnt is clog2(CBITS) bits and rowcnt is clog2(ROWS) bits, each minimum 1 bit. Neither wraps inside a load; both clear on entry to FETCH/IDLE as applicable.
- wvalid held low in FETCH: the loader stalls indefinitely with shift_en=0. The cell chain contents are unchanged.
- Reset mid-load: immediate return to IDLE with arr_reset=1. The partial configuration is invalid and the array stays in reset until a full load completes.

Optional Feature:
- Macro: CFG_READBACK_EN.
- With it: on every shift_en cycle, cbitret[c] is sampled before the edge and shifted into the LSB of readback field c.
  - After the CBITS-th shift of a row, rvalid=1 for one cycle and rdata holds the assembled word. There is no backpressure.
  - Word k returned is the previous configuration of row ROWS-1-k, in the same field layout as wdata.
  - Reset clears rdata and rvalid.
- Without it: rdata=0, rvalid=0 constant, cbitret unused, no readback registers.

Test Plan:
- Use COLS=2, ROWS=2, CBITS=3 throughout.
- Reset, then idle -> arr_reset=1, busy=0, wready=0, shift_en=0; start while reset is high is ignored.
- start; words 6'b011_001 then 6'b110_010, wvalid held high:
  - cbit[0] sequence is 0,0,1 then 0,1,0; cbit[1] sequence is 0,1,1 then 1,1,0.
  - shift_en high for 3 of every 4 cycles; done at cycle 9; arr_reset falls the cycle after done.
- Stall: wvalid low for 5 cycles in FETCH -> shift_en=0 and wready=1 throughout; the load resumes unchanged and done is delayed by 5 cycles.
- reset asserted in the 2nd SHIFT cycle of row 1 -> next cycle IDLE, arr_reset=1, busy=0. A following start and full load completes normally.
- start pulses during SHIFT and DONE -> ignored; no second load, busy falls after exactly one load.
- CFG_READBACK_EN: model a 2-row chain, load A then load B -> rvalid pulses twice during load B, rdata equals A's row words in the order accepted (bottom row first). Without the macro, rvalid stays 0.
